ofdm_symbol_mapper: RTL
=======================

Name: ofdm_symbol_mapper

Overview:
- Parametrised multi-mode constellation mapper for the 802.11 OFDM transmit chain. It replaces the fixed QPSK modulation stage in front of pilot insertion.
- Accepts an IN_W-bit Wishbone-style bit stream and regroups bits through an internal gearbox. It emits one complex symbol per output beat, mapped as BPSK, QPSK or 16-QAM with 802.11 Gray coding.
- It has a registered, backpressure-aware output handshake.

Parameters:
- IN_W, 2, input bits per beat; legal range 1..4.
- DW, 16, width of each of I and Q; signed two's complement.
- LVL_BPSK, 16384, BPSK amplitude (1.0 in Q2.14).
- LVL_QPSK, 11585, QPSK per-axis amplitude (1/sqrt2).
- LVL_QAM16, 5181, 16-QAM unit level (1/sqrt10); outer level is 3*LVL_QAM16.

Ports:
- CLK_I  in  1  clock; all logic on rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- DAT_I  in  IN_W  input bits; DAT_I[0] is the earliest bit.
- MODE_I  in  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=reserved (treated as QPSK).
- CYC_I, STB_I, WE_I  in  1 each  upstream frame / strobe / write.
- ACK_O  out  1  input beat accepted.
- DAT_O  out  2*DW  {I, Q}: I in the upper DW bits, Q in the lower DW bits.
- CYC_O, STB_O, WE_O  out  1 each  downstream frame / strobe / write; WE_O equals STB_O.
- ACK_I  in  1  downstream accept.

Behaviour:
- Reset (RST_I=0, asynchronous): DAT_O=0, STB_O=0, CYC_O=0, WE_O=0; accumulator count cnt=0; state IDLE; latched mode = QPSK.
- Bits per symbol: bps = 1, 2 or 4 from the latched mode.
- Accumulator: 8-bit shift register, LSB-first, with count cnt in 0..8.
- Input acceptance:
  - Beat accepted when CYC_I & STB_I & WE_I & ACK_O.
  - ACK_O is combinational: asserted when CYC_I & STB_I & WE_I & (cnt - emit_bits + IN_W <= 8).
  - emit_bits = bps if a symbol is formed this cycle, else 0.
- Symbol formation:
  - A symbol is formed when cnt >= bps and the output register is free (STB_O=0, or STB_O&ACK_I).
  - Forming a symbol consumes the bps lowest accumulator bits. Shift-out and shift-in happen in the same cycle.
  - Bits accepted in a given cycle do not contribute to a symbol formed in that same cycle.
- Latency: a beat accepted at edge n that completes a symbol gives STB_O=1 with valid DAT_O after edge n+1.
- Output hold: while STB_O=1 and ACK_I=0, DAT_O and STB_O are held stable.
- Mapping (b0 = oldest bit):
  - BPSK: I = b0 ? +LVL_BPSK : -LVL_BPSK; Q = 0.
  - QPSK: I from b0, Q from b1; 1 gives +LVL_QPSK, 0 gives -LVL_QPSK.
  - 16-QAM: I from b0b1, Q from b2b3. Code 00 gives -3L, 01 gives -L, 11 gives +L, 10 gives +3L, where L = LVL_QAM16.
- State machine:
  - IDLE → RUN on the first accepted beat. MODE_I is latched on that beat and held for the frame; MODE_I changes mid-frame are ignored.
  - RUN → DRAIN when CYC_I falls.
  - DRAIN: no input accepted; remaining full symbols are emitted. DRAIN → IDLE when cnt < bps and the output register is free; residual bits are then handled per the optional feature and cnt is cleared to 0.
  - CYC_I reasserting while in DRAIN is not acknowledged until IDLE is reached.
- CYC_O: 1 from the first accepted beat until the DRAIN → IDLE transition.
- Full accumulator: ACK_O=0 and upstream stalls.
- Empty accumulator with STB_O held: no symbol is formed.
- Reset mid-frame: all state and the pending symbol are discarded immediately.

Optional Feature:
- FLUSH_PAD_EN defined: in DRAIN, if 0 < cnt < bps, the residual bits are zero-padded to bps and emitted as one final symbol before IDLE.
- FLUSH_PAD_EN undefined: residual bits are silently dropped.

Test Plan:
- QPSK, IN_W=2, one beat DAT_I=2'b01, ACK_I=1 → one cycle later STB_O=1, DAT_O=32'h2D41_D2BF.
- BPSK, one beat 2'b10 → two consecutive symbols: 32'hC000_0000, then 32'h4000_0000. ACK_O stays high for the next beat.
- 16-QAM, beats 2'b10 then 2'b01 → one symbol DAT_O=32'hEBC3_3CB7, presented after the second beat. No symbol after the first beat.
- QPSK streaming, ACK_I held low 5 cycles → DAT_O is constant throughout. ACK_O drops once cnt would exceed 8. Streaming resumes with no lost or duplicated symbols.
- 16-QAM, 3 beats then CYC_I low → one symbol, then 2 residual bits:
  - with FLUSH_PAD_EN, a second symbol with b2=b3=0 is emitted;
  - without FLUSH_PAD_EN, no second symbol;
  - in both cases CYC_O falls, then returns to IDLE.
- RST_I pulsed low mid-frame while STB_O=1 → all outputs are 0 immediately. The next frame maps correctly using the newly latched MODE_I.

Source files
------------

// File: rtl/ofdm_symbol_mapper.sv
// ofdm_symbol_mapper: multi-mode (BPSK / QPSK / 16-QAM) constellation mapper
// for the 802.11 OFDM transmit chain. It collects a Wishbone-style bit stream
// in an 8-bit LSB-first gearbox and emits one Gray-coded complex symbol per
// output beat through a registered, backpressure-aware handshake.
// Optional build macro: FLUSH_PAD_EN. When it is defined, residual bits left
// at end of frame are zero-padded into one final symbol. When it is not
// defined, those residual bits are dropped.
module ofdm_symbol_mapper #(
  parameter int IN_W      = 2,
  parameter int DW        = 16,
  parameter int LVL_BPSK  = 16384,
  parameter int LVL_QPSK  = 11585,
  parameter int LVL_QAM16 = 5181
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [IN_W-1:0] DAT_I,
  input  logic [1:0]      MODE_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  output logic            ACK_O,
  output logic [2*DW-1:0] DAT_O,
  output logic            CYC_O,
  output logic            STB_O,
  output logic            WE_O,
  input  logic            ACK_I
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [DW-1:0] BPSK_P = DW'(LVL_BPSK);
  localparam logic [DW-1:0] BPSK_N = DW'(-LVL_BPSK);
  localparam logic [DW-1:0] QPSK_P = DW'(LVL_QPSK);
  localparam logic [DW-1:0] QPSK_N = DW'(-LVL_QPSK);
  localparam logic [DW-1:0] QAM1_P = DW'(LVL_QAM16);
  localparam logic [DW-1:0] QAM1_N = DW'(-LVL_QAM16);
  localparam logic [DW-1:0] QAM3_P = DW'(3 * LVL_QAM16);
  localparam logic [DW-1:0] QAM3_N = DW'(-3 * LVL_QAM16);
  localparam logic [4:0]    IN_W_5 = 5'(IN_W);
  localparam logic [3:0]    IN_W_4 = 4'(IN_W);

  state_t          state;
  state_t          state_next;
  logic [1:0]      mode_q;
  logic [7:0]      acc;
  logic [3:0]      cnt;
  logic            stb_q;
  logic [2*DW-1:0] dat_q;

  logic [3:0]      bps;
  logic            out_free;
  logic            full_form;
  logic            pad_form;
  logic            form;
  logic [3:0]      emit_bits;
  logic [3:0]      cnt_after;
  logic [4:0]      fill_after;
  logic            accept;
  logic            drain_done;
  logic [11:0]     acc_shift;
  logic [11:0]     acc_in;
  logic [11:0]     acc_wide;
  logic [3:0]      cnt_next;
  logic [DW-1:0]   sym_i;
  logic [DW-1:0]   sym_q;

  // Bits per symbol follow the mode latched at the start of the frame
  always_comb begin
    bps = 4'd2;
    case (mode_q)
      2'd0:    bps = 4'd1;
      2'd2:    bps = 4'd4;
      default: bps = 4'd2;
    endcase
  end

  // Symbol formation, gearbox accounting and input acceptance for this cycle;
  // incoming bits land above whatever survives the shift-out, so they never
  // feed a symbol formed in the same cycle
  always_comb begin
    out_free  = !stb_q || ACK_I;
    full_form = (state != IDLE) && (cnt >= bps) && out_free;
`ifdef FLUSH_PAD_EN
    pad_form  = (state == DRAIN) && (cnt != 4'd0) && (cnt < bps) && out_free;
`else
    pad_form  = 1'b0;
`endif
    form       = full_form || pad_form;
    emit_bits  = full_form ? bps : (pad_form ? cnt : 4'd0);
    cnt_after  = cnt - emit_bits;
    fill_after = {1'b0, cnt_after} + IN_W_5;
    accept     = CYC_I && STB_I && WE_I && (state != DRAIN) && (fill_after <= 5'd8);
    drain_done = (state == DRAIN) && (cnt < bps) && out_free && !pad_form;
    acc_shift  = {4'b0000, acc} >> emit_bits;
    acc_in     = {{(12 - IN_W){1'b0}}, DAT_I} << cnt_after;
    acc_wide   = accept ? (acc_shift | acc_in) : acc_shift;
    cnt_next   = cnt_after + (accept ? IN_W_4 : 4'd0);
  end

  // Gray-coded constellation lookup on the oldest accumulator bits; bits
  // above cnt are always zero, so a padded symbol needs no extra masking
  always_comb begin
    sym_i = '0;
    sym_q = '0;
    case (mode_q)
      2'd0: begin
        sym_i = acc[0] ? BPSK_P : BPSK_N;
      end
      2'd2: begin
        sym_i = acc[0] ? (acc[1] ? QAM1_P : QAM3_P) : (acc[1] ? QAM1_N : QAM3_N);
        sym_q = acc[2] ? (acc[3] ? QAM1_P : QAM3_P) : (acc[3] ? QAM1_N : QAM3_N);
      end
      default: begin
        sym_i = acc[0] ? QPSK_P : QPSK_N;
        sym_q = acc[1] ? QPSK_P : QPSK_N;
      end
    endcase
  end

  // Frame state register
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state <= IDLE;
    else        state <= state_next;
  end

  // Frame sequencing: open on first accepted beat, drain when CYC_I drops
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = RUN;
      RUN:     if (!CYC_I)     state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gearbox contents, latched mode and the registered output beat
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      acc    <= '0;
      cnt    <= '0;
      mode_q <= 2'd1;
      stb_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      if (drain_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_wide[7:0];
        cnt <= cnt_next;
      end
      if ((state == IDLE) && accept) begin
        mode_q <= (MODE_I == 2'd3) ? 2'd1 : MODE_I;
      end
      if (form) begin
        dat_q <= {sym_i, sym_q};
        stb_q <= 1'b1;
      end else if (ACK_I) begin
        stb_q <= 1'b0;
      end
    end
  end

  assign ACK_O = accept;
  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;
  assign CYC_O = (state != IDLE);

endmodule
